// File: rtl/rf_arb_pkg.sv
// Shared types, defaults and the round-robin pick function for the regfile writeback arbiter.
package rf_arb_pkg;

  localparam int unsigned NumReqDef = 3;
  localparam int unsigned DataWDef  = 32;
  localparam int unsigned AddrWDef  = 5;

  // Upper bound on requesters supported by rr_pick.
  localparam int unsigned MaxReq = 16;
  localparam int unsigned IdxW   = $clog2(MaxReq);

  typedef struct packed {
    logic [AddrWDef-1:0] rd;
    logic [DataWDef-1:0] data;
  } wb_req_t;

  // One-hot grant to the first valid requester at or after ptr, wrapping modulo n.
  function automatic logic [MaxReq-1:0] rr_pick(input logic [MaxReq-1:0] valid,
                                                input int unsigned       ptr,
                                                input int unsigned       n);
    logic [MaxReq-1:0] grant;
    logic              found;
    int unsigned       idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      idx = (ptr + i) % n;
      if (i < n && !found && valid[idx[IdxW-1:0]]) begin
        grant[idx[IdxW-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bus: packed per-requester valid/rd/data with a one-hot ready back.
interface rf_wb_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_rd;
  logic [NUM_REQ*DATA_W-1:0] req_data;

  modport master (
    output req_valid,
    output req_rd,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_rd,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// NUM_REQ-wide one-hot grant with a rotating priority pointer.
// Define RF_WB_FIXED_PRIO_EN for fixed lowest-index-wins priority with no pointer.
module rr_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NumReqDef
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid_i,
  output logic [NUM_REQ-1:0] grant_o
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [MaxReq-1:0] valid_ext;
  logic [MaxReq-1:0] pick;

  always_comb begin
    valid_ext              = '0;
    valid_ext[NUM_REQ-1:0] = valid_i;
  end

`ifdef RF_WB_FIXED_PRIO_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign pick           = rr_pick(valid_ext, 0, NUM_REQ);
`else
  logic [PtrW-1:0] ptr_q, ptr_d;

  assign pick = rr_pick(valid_ext, 32'(ptr_q), NUM_REQ);

  always_comb begin
    ptr_d = ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) ptr_d = PtrW'((i + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end
`endif

  if (NUM_REQ < MaxReq) begin : g_unused
    logic unused_pick;
    assign unused_pick = ^pick[MaxReq-1:NUM_REQ];
  end

  assign grant_o = pick[NUM_REQ-1:0];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Regfile write-port controller: arbitrates writeback requesters onto one registered write
// port and keeps a pending-write scoreboard for decode. RF_WB_FIXED_PRIO_EN selects fixed priority.
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NumReqDef,
  parameter int unsigned DATA_W  = DataWDef,
  parameter int unsigned ADDR_W  = AddrWDef
) (
  input  logic                 clk,
  input  logic                 rst,
  rf_wb_arbiter_if.slave       wb,
  output logic                 rf_w_en_o,
  output logic [ADDR_W-1:0]    rf_rd_id_o,
  output logic [DATA_W-1:0]    rf_wdata_o,
  input  logic                 issue_valid_i,
  input  logic [ADDR_W-1:0]    issue_rd_i,
  input  logic                 issue_wr_i,
  input  logic [ADDR_W-1:0]    rs1_id_i,
  input  logic [ADDR_W-1:0]    rs2_id_i,
  output logic                 issue_stall_o,
  output logic [2**ADDR_W-1:0] busy_o
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [NUM_REQ-1:0] valid_gated;
  logic [NUM_REQ-1:0] grant;
  logic               any_grant;
  logic [ADDR_W-1:0]  sel_rd;
  logic [DATA_W-1:0]  sel_data;

  logic               w_en_q, w_en_d;
  logic [ADDR_W-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [NumRegs-1:0] busy_q, busy_d;
  logic               set_en;

  // Requests seen during reset are ignored so nothing is granted then.
  assign valid_gated = wb.req_valid & {NUM_REQ{rst}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_gated),
    .grant_o (grant)
  );

  assign wb.req_ready = grant;
  assign any_grant    = |grant;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_rd   = sel_rd | wb.req_rd[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | wb.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // x0 writes are accepted but never reach the regfile.
  always_comb begin
    w_en_d = any_grant & (|sel_rd);
    rd_d   = any_grant ? sel_rd : rd_q;
    data_d = any_grant ? sel_data : data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_en_q <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      w_en_q <= w_en_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  assign issue_stall_o = issue_valid_i &
                         (busy_q[rs1_id_i] | busy_q[rs2_id_i] | (issue_wr_i & busy_q[issue_rd_i]));
  assign set_en        = issue_valid_i & ~issue_stall_o & issue_wr_i & (|issue_rd_i);

  // Set is applied after clear so a same-index collision leaves the bit busy.
  always_comb begin
    busy_d = busy_q;
    if (w_en_q) busy_d[rd_q] = 1'b0;
    if (set_en) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign rf_w_en_o  = w_en_q;
  assign rf_rd_id_o = rd_q;
  assign rf_wdata_o = data_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (honours RF_WB_FIXED_PRIO_EN if defined).
module tb_rf_wb_arbiter;

  localparam int unsigned NReq = 3;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          rf_w_en;
  logic [AW-1:0] rf_rd_id;
  logic [DW-1:0] rf_wdata;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic          issue_wr;
  logic [AW-1:0] rs1_id;
  logic [AW-1:0] rs2_id;
  logic          issue_stall;
  logic [31:0]   busy;

  int errors = 0;
  int checks = 0;

  rf_wb_arbiter_if #(.NUM_REQ(NReq), .DATA_W(DW), .ADDR_W(AW)) bus ();

  rf_wb_arbiter #(
    .NUM_REQ (NReq),
    .DATA_W  (DW),
    .ADDR_W  (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wb            (bus),
    .rf_w_en_o     (rf_w_en),
    .rf_rd_id_o    (rf_rd_id),
    .rf_wdata_o    (rf_wdata),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .issue_wr_i    (issue_wr),
    .rs1_id_i      (rs1_id),
    .rs2_id_i      (rs2_id),
    .issue_stall_o (issue_stall),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic v, input logic [AW-1:0] rd,
                         input logic [DW-1:0] d);
    bus.req_valid[idx]        = v;
    bus.req_rd[idx*AW +: AW]  = rd;
    bus.req_data[idx*DW +: DW] = d;
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_rd    = '0;
    bus.req_data  = '0;
    issue_valid   = 1'b0;
    issue_rd      = '0;
    issue_wr      = 1'b0;
    rs1_id        = '0;
    rs2_id        = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < int'(NReq); i++) set_req(i, 1'b1, AW'(3 + i), 32'hA5A5_0000 + DW'(i));
    issue_valid = 1'b1;
    issue_wr    = 1'b1;
    issue_rd    = 5'd3;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (bus.req_ready !== 3'b000) begin
        errors++; $display("FAIL reset_ready cyc=%0d got=%b want=000", c, bus.req_ready);
      end
      checks++;
      if (rf_w_en !== 1'b0) begin
        errors++; $display("FAIL reset_wen cyc=%0d got=%b want=0", c, rf_w_en);
      end
      checks++;
      if (busy !== 32'h0) begin
        errors++; $display("FAIL reset_busy cyc=%0d got=%h want=0", c, busy);
      end
    end
    checks++;
    if (rf_rd_id !== 5'd0 || rf_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_regs got rd=%0d data=%h want rd=0 data=0", rf_rd_id, rf_wdata);
    end
    clear_inputs();
    rst = 1'b1;
  endtask

  task automatic test_single_write();
    set_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    checks++;
    if (bus.req_ready !== 3'b001) begin
      errors++; $display("FAIL single_ready got=%b want=001", bus.req_ready);
    end
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (rf_w_en !== 1'b1 || rf_rd_id !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_write got en=%b rd=%0d data=%h want en=1 rd=5 data=deadbeef",
               rf_w_en, rf_rd_id, rf_wdata);
    end
    step();
    checks++;
    if (rf_w_en !== 1'b0 || rf_rd_id !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_hold got en=%b rd=%0d data=%h want en=0 rd=5 data=deadbeef",
               rf_w_en, rf_rd_id, rf_wdata);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g;
    int         g;
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < int'(NReq); i++) set_req(i, 1'b1, AW'(i + 1), 32'h0000_00A0 + DW'(i));
    for (int k = 0; k < 6; k++) begin
`ifdef RF_WB_FIXED_PRIO_EN
      g = 0;
`else
      g = k % 3;
`endif
      exp_g = 3'b001 << g;
      #1;
      checks++;
      if (bus.req_ready !== exp_g) begin
        errors++; $display("FAIL rr_grant k=%0d got=%b want=%b", k, bus.req_ready, exp_g);
      end
      step();
      checks++;
      if (rf_w_en !== 1'b1 || rf_rd_id !== AW'(g + 1) || rf_wdata !== 32'h0000_00A0 + DW'(g)) begin
        errors++;
        $display("FAIL rr_write k=%0d got en=%b rd=%0d data=%h want en=1 rd=%0d data=%h", k,
                 rf_w_en, rf_rd_id, rf_wdata, g + 1, 32'h0000_00A0 + DW'(g));
      end
    end
    clear_inputs();
    step();
  endtask

  task automatic test_x0_drop();
    set_req(1, 1'b1, 5'd0, 32'h0000_1234);
    #1;
    checks++;
    if (bus.req_ready !== 3'b010) begin
      errors++; $display("FAIL x0_ready got=%b want=010", bus.req_ready);
    end
    step();
    set_req(1, 1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (rf_w_en !== 1'b0 || rf_rd_id !== 5'd0 || rf_wdata !== 32'h0000_1234) begin
      errors++;
      $display("FAIL x0_write got en=%b rd=%0d data=%h want en=0 rd=0 data=00001234",
               rf_w_en, rf_rd_id, rf_wdata);
    end
  endtask

  task automatic test_raw_stall();
    issue_valid = 1'b1;
    issue_wr    = 1'b1;
    issue_rd    = 5'd7;
    #1;
    checks++;
    if (issue_stall !== 1'b0) begin
      errors++; $display("FAIL raw_first_issue got=%b want=0", issue_stall);
    end
    step();
    issue_wr = 1'b0;
    rs1_id   = 5'd7;
    #1;
    checks++;
    if (busy !== 32'h0000_0080) begin
      errors++; $display("FAIL raw_busy_set got=%h want=00000080", busy);
    end
    checks++;
    if (issue_stall !== 1'b1) begin
      errors++; $display("FAIL raw_stall got=%b want=1", issue_stall);
    end
    set_req(2, 1'b1, 5'd7, 32'h0000_0077);
    #1;
    checks++;
    if (bus.req_ready !== 3'b100) begin
      errors++; $display("FAIL raw_wb_ready got=%b want=100", bus.req_ready);
    end
    step();
    set_req(2, 1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (rf_w_en !== 1'b1 || rf_rd_id !== 5'd7 || issue_stall !== 1'b1) begin
      errors++;
      $display("FAIL raw_wb_cycle got en=%b rd=%0d stall=%b want en=1 rd=7 stall=1",
               rf_w_en, rf_rd_id, issue_stall);
    end
    step();
    checks++;
    if (issue_stall !== 1'b0 || busy !== 32'h0) begin
      errors++;
      $display("FAIL raw_release got stall=%b busy=%h want stall=0 busy=0", issue_stall, busy);
    end
    issue_valid = 1'b0;
    #1;
    checks++;
    if (issue_stall !== 1'b0) begin
      errors++; $display("FAIL raw_idle got=%b want=0", issue_stall);
    end
    clear_inputs();
  endtask

  task automatic test_collision();
    set_req(0, 1'b1, 5'd9, 32'h0000_0099);
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    issue_valid = 1'b1;
    issue_wr    = 1'b1;
    issue_rd    = 5'd9;
    #1;
    checks++;
    if (rf_w_en !== 1'b1 || rf_rd_id !== 5'd9 || issue_stall !== 1'b0) begin
      errors++;
      $display("FAIL coll_setup got en=%b rd=%0d stall=%b want en=1 rd=9 stall=0",
               rf_w_en, rf_rd_id, issue_stall);
    end
    step();
    issue_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 32'h0000_0200) begin
      errors++; $display("FAIL coll_set_wins got=%h want=00000200", busy);
    end
    set_req(0, 1'b1, 5'd9, 32'h0000_009A);
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    step();
    checks++;
    if (busy !== 32'h0) begin
      errors++; $display("FAIL coll_clear got=%h want=0", busy);
    end
    clear_inputs();
  endtask

  task automatic test_mid_reset();
    set_req(0, 1'b1, 5'd4, 32'h0000_0044);
    issue_valid = 1'b1;
    issue_wr    = 1'b1;
    issue_rd    = 5'd12;
    step();
    clear_inputs();
    #1;
    checks++;
    if (rf_w_en !== 1'b1 || busy !== 32'h0000_1000) begin
      errors++;
      $display("FAIL midrst_setup got en=%b busy=%h want en=1 busy=00001000", rf_w_en, busy);
    end
    rst = 1'b0;
    step();
    checks++;
    if (rf_w_en !== 1'b0 || busy !== 32'h0) begin
      errors++;
      $display("FAIL midrst_drop got en=%b busy=%h want en=0 busy=0", rf_w_en, busy);
    end
    rst = 1'b1;
    step();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_round_robin();
    test_x0_drop();
    test_raw_stall();
    test_collision();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Controller for the register file's single write port.
- Arbitrates NUM_REQ writeback requesters (ALU writeback, load unit, debug/simulator poke) onto one registered write port: w_en, rd_id, write data.
- Maintains a pending-write scoreboard so decode can stall on RAW/WAW hazards.
- Sits between the execute/memory writeback paths and the regfile instance inside decode.

Parameters:
- NUM_REQ, 3, number of writeback requesters; index 0 has highest priority on reset.
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width (2^ADDR_W registers).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester write request.
- req_ready_o  out  NUM_REQ  per-requester grant; one-hot or zero.
- req_rd_i  in  NUM_REQ*ADDR_W  packed destination indices; requester i at bits [i*ADDR_W +: ADDR_W].
- req_data_i  in  NUM_REQ*DATA_W  packed write data; same packing as req_rd_i.
- rf_w_en_o  out  1  regfile write enable.
- rf_rd_id_o  out  ADDR_W  regfile write index.
- rf_wdata_o  out  DATA_W  regfile write data.
- issue_valid_i  in  1  decode wants to issue an instruction.
- issue_rd_i  in  ADDR_W  destination of the issuing instruction.
- issue_wr_i  in  1  issuing instruction writes a register.
- rs1_id_i  in  ADDR_W  source index 1 of the issuing instruction.
- rs2_id_i  in  ADDR_W  source index 2 of the issuing instruction.
- issue_stall_o  out  1  hazard; decode must hold.
- busy_o  out  2^ADDR_W  scoreboard bits, for debug.

Behaviour:
- Reset (rst==0 at a clock edge):
  - rf_w_en_o=0, rf_rd_id_o=0, rf_wdata_o=0.
  - busy all 0.
  - Round-robin pointer=0.
  - req_ready_o is combinational; it reads 0 whenever no request is valid.
- Arbitration:
  - Combinational round-robin starting at the pointer; grant the first valid requester.
  - req_ready_o[g]=1 only when req_valid_i[g]=1.
  - Handshake: a transfer occurs when valid&ready.
  - Requesters hold valid, rd and data stable until ready.
- Pointer update: after a grant to g, the pointer becomes (g+1) mod NUM_REQ. With no grant, the pointer is unchanged.
- Write stage (registered, latency 1):
  - On a grant edge: rf_w_en_o <= (rd!=0), rf_rd_id_o <= rd, rf_wdata_o <= data.
  - With no grant: rf_w_en_o <= 0; rd_id and data hold.
  - Exactly one regfile write per cycle maximum.
- x0 handling:
  - Writes to index 0 are accepted (ready asserted) but never drive rf_w_en_o.
  - busy[0] is always 0.
- Scoreboard stall:
  - issue_stall_o = issue_valid_i & (busy[rs1] | busy[rs2] | (issue_wr_i & busy[issue_rd_i])).
  - It is purely combinational from current busy bits.
- Scoreboard set: when issue_valid_i & ~issue_stall_o & issue_wr_i & issue_rd_i!=0, busy[issue_rd_i] <= 1.
- Scoreboard clear:
  - At the edge where rf_w_en_o==1, busy[rf_rd_id_o] <= 0.
  - The regfile commits on that same edge, so the next cycle reads the new value.
- Simultaneous set and clear of the same index: set wins; busy stays 1.
- Reset mid-operation: pending write-stage content is dropped (w_en forced 0) and all busy bits clear.
- Requesters must drop in-flight requests under reset; the block ignores req_valid_i while rst==0.

Optional Feature:
- Macro: RF_WB_FIXED_PRIO_EN.
- Defined:
  - Fixed priority; lowest index wins.
  - Pointer logic is removed.
  - The debug requester (highest index) can starve.
- Undefined (default): round-robin as above.

Decomposition:
- Shared package rf_arb_pkg holds:
  - localparams for default DATA_W/ADDR_W/NUM_REQ;
  - a packed typedef wb_req_t {rd, data};
  - function rr_pick(valid, ptr) returning one-hot grant.
- One sub-module is natural: rr_arbiter (NUM_REQ-wide grant plus pointer register).
- Scoreboard and write stage stay in the top.

Test Plan:
- Reset: hold rst=0 for 2 cycles with all inputs active -> rf_w_en_o=0, busy_o=0, req_ready_o=0 throughout.
- Single write:
  - Stimulus: req0 valid, rd=5, data=0xDEADBEEF.
  - Response: ready0 same cycle; next cycle rf_w_en_o=1, rf_rd_id_o=5, rf_wdata_o=0xDEADBEEF.
- Round-robin: all three valid continuously from reset -> grants 0,1,2,0,1,2 on consecutive cycles. Under RF_WB_FIXED_PRIO_EN -> grants 0 every cycle.
- x0 drop: req1 writes rd=0 data=0x1234 -> ready1=1; next cycle rf_w_en_o=0.
- RAW stall:
  - Issue rd=7 (busy[7]=1), then issue rs1=7 -> issue_stall_o=1.
  - Writeback of rd=7 is granted -> stall deasserts the cycle after rf_w_en_o=1.
- Set/clear collision: rf_w_en_o=1 for rd=9 while a non-stalled issue with rd=9 occurs the same cycle -> busy[9] remains 1.
